// File: rtl/circular_shift_pipelined_variable.sv
// circular_shift_pipelined_variable: SW-stage valid/ready rotator; stage k rotates by 2^k under amt bit k.
// Define CIRC_SHIFT_OUT_REG_EN to add one output register stage (latency SW+1).
module circular_shift_pipelined_variable #(
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arg_vld,
    output logic          arg_rdy,
    input  logic [N-1:0]  arg,
    input  logic [SW-1:0] amt,
    input  logic          dir,
    output logic          res_vld,
    input  logic          res_rdy,
    output logic [N-1:0]  res
);

    logic          vld   [SW];
    logic [N-1:0]  data  [SW];
    logic [SW-1:0] amt_r [SW];
    logic          dir_r [SW];
    logic [N-1:0]  nxt   [SW];
    logic          stall;

    // sh is always in 1..N/2, so N-sh never reaches N and no bits are lost
    function automatic logic [N-1:0] rot(input logic [N-1:0] x, input int unsigned sh,
                                         input logic right);
        logic [N-1:0] r;
        if (right)
            r = (x >> sh) | (x << (N - sh));
        else
            r = (x << sh) | (x >> (N - sh));
        return r;
    endfunction

    assign nxt[0] = amt[0] ? rot(arg, 1, dir) : arg;

    for (genvar k = 1; k < SW; k++) begin : g_stage
        assign nxt[k] = amt_r[k-1][k] ? rot(data[k-1], 2 ** k, dir_r[k-1]) : data[k-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < SW; k++) begin
                vld[k]   <= 1'b0;
                data[k]  <= '0;
                amt_r[k] <= '0;
                dir_r[k] <= 1'b0;
            end
        end else if (!stall) begin
            vld[0] <= arg_vld;
            if (arg_vld) begin
                data[0]  <= nxt[0];
                amt_r[0] <= amt;
                dir_r[0] <= dir;
            end
            for (int unsigned k = 1; k < SW; k++) begin
                vld[k]   <= vld[k-1];
                data[k]  <= nxt[k];
                amt_r[k] <= amt_r[k-1];
                dir_r[k] <= dir_r[k-1];
            end
        end
    end

`ifdef CIRC_SHIFT_OUT_REG_EN
    logic         out_vld;
    logic [N-1:0] out_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (!stall) begin
            out_vld  <= vld[SW-1];
            out_data <= data[SW-1];
        end
    end

    assign res_vld = out_vld;
    assign res     = out_data;
`else
    assign res_vld = vld[SW-1];
    assign res     = data[SW-1];
`endif

    assign stall   = res_vld && !res_rdy;
    assign arg_rdy = !stall;

endmodule

// File: tb/tb_circular_shift_pipelined_variable.sv
// Self-checking bench for circular_shift_pipelined_variable: directed cases plus a
// randomized stream checked every cycle against a time-tagged reference queue.
module tb_circular_shift_pipelined_variable;
    localparam int N  = 8;
    localparam int SW = $clog2(N);
`ifdef CIRC_SHIFT_OUT_REG_EN
    localparam int LAT = SW + 1;
`else
    localparam int LAT = SW;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arg_vld = 1'b0;
    logic          arg_rdy;
    logic [N-1:0]  arg = '0;
    logic [SW-1:0] amt = '0;
    logic          dir = 1'b0;
    logic          res_vld;
    logic          res_rdy = 1'b1;
    logic [N-1:0]  res;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    circular_shift_pipelined_variable #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .arg_vld (arg_vld),
        .arg_rdy (arg_rdy),
        .arg     (arg),
        .amt     (amt),
        .dir     (dir),
        .res_vld (res_vld),
        .res_rdy (res_rdy),
        .res     (res)
    );

    function automatic logic [N-1:0] rot_model(input logic [N-1:0] x, input int s, input logic right);
        logic [N-1:0] o;
        o = '0;
        for (int i = 0; i < N; i++) begin
            if (right) o[i] = x[(i + s) % N];
            else       o[(i + s) % N] = x[i];
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each accepted word is due when the un-stalled cycle count reaches accept+LAT.
    typedef struct {
        logic [N-1:0] val;
        longint       due;
    } ent_t;

    ent_t   q[$];
    longint ptime = 0;
    logic   sb_exp;
    logic   sb_stall;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            sb_exp   = (q.size() > 0) && (q[0].due == ptime);
            sb_stall = sb_exp && !res_rdy;
            chk("sb_res_vld", res_vld, sb_exp);
            chk("sb_arg_rdy", arg_rdy, !sb_stall);
            if (sb_exp && res_vld) chk("sb_res", res, q[0].val);
            if (sb_exp && res_rdy) void'(q.pop_front());
            if (arg_vld && !sb_stall) q.push_back('{rot_model(arg, int'(amt), dir), ptime + LAT});
            if (!sb_stall) ptime++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic one_word(input logic [N-1:0] a, input logic [SW-1:0] s, input logic d,
                            input logic [N-1:0] exp, input string name);
        arg = a; amt = s; dir = d; arg_vld = 1'b1; res_rdy = 1'b1;
        #1;
        chk({name, "_rdy"}, arg_rdy, 1'b1);
        for (int c = 1; c <= LAT; c++) begin
            tick();
            arg_vld = 1'b0;
            if (c < LAT) begin
                chk({name, "_early"}, res_vld, 1'b0);
            end else begin
                chk({name, "_vld"}, res_vld, 1'b1);
                chk(name, res, exp);
            end
        end
        tick();
    endtask

    logic [N-1:0] r0, r1, r2, e;
    int accepted;
    int cyc;

    initial begin
        // Pin the reference rotation to hand-computed values.
        chk("model_r3",  rot_model(8'b10110101, 3, 1'b1), 8'b10110110);
        chk("model_l3",  rot_model(8'b10110101, 3, 1'b0), 8'b10101101);
        chk("model_r7",  rot_model(8'b00100110, 7, 1'b1), 8'b01001100);
        chk("model_l1",  rot_model(8'b00100110, 1, 1'b0), 8'b01001100);

        repeat (2) tick();
        rst = 1'b0;
        chk("rst_res_vld", res_vld, 1'b0);
        chk("rst_res", res, 8'h00);
        chk("rst_arg_rdy", arg_rdy, 1'b1);

        one_word(8'b10110101, 3'd3, 1'b1, 8'b10110110, "t1_right3");
        one_word(8'b10110101, 3'd3, 1'b0, 8'b10101101, "t1_left3");
        one_word(8'h5A,       3'd0, 1'b1, 8'h5A,       "amt0");

        // Back-to-back stream of single-bit walking words.
        for (int t = 0; t <= 8 + LAT - 2; t++) begin
            if (t < 8) begin
                arg = 8'h01; amt = SW'(t); dir = 1'b0; arg_vld = 1'b1;
                #1;
                chk("stream_arg_rdy", arg_rdy, 1'b1);
            end else begin
                arg_vld = 1'b0;
            end
            tick();
            if (t >= LAT - 1) begin
                e = 8'h01 << (t - LAT + 1);
                chk("stream_vld", res_vld, 1'b1);
                chk("stream_res", res, e);
            end
        end
        arg_vld = 1'b0;
        repeat (2) tick();

        // Fill three words against a stalled output, hold, then drain.
        r0 = rot_model(8'hC3, 1, 1'b0);
        r1 = rot_model(8'h81, 2, 1'b1);
        r2 = rot_model(8'h3C, 6, 1'b0);
        res_rdy = 1'b0;
        arg = 8'hC3; amt = 3'd1; dir = 1'b0; arg_vld = 1'b1; tick();
        arg = 8'h81; amt = 3'd2; dir = 1'b1; tick();
        arg = 8'h3C; amt = 3'd6; dir = 1'b0; tick();
        arg_vld = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("stall_arg_rdy", arg_rdy, 1'b0);
            chk("stall_vld", res_vld, 1'b1);
            chk("stall_res", res, r0);
        end
        res_rdy = 1'b1;
        #1;
        chk("drain0", res, r0);
        tick();
        chk("drain1", res, r1);
        chk("drain1_vld", res_vld, 1'b1);
        tick();
        chk("drain2", res, r2);
        chk("drain2_vld", res_vld, 1'b1);
        tick();
        chk("drain_empty", res_vld, 1'b0);

        // Edge values, right rotation.
        one_word(8'hFF,       3'd5, 1'b1, 8'hFF,       "edge_ff");
        one_word(8'h00,       3'd7, 1'b1, 8'h00,       "edge_00");
        one_word(8'b01100110, 3'd3, 1'b1, 8'b11001100, "edge_r3");
        one_word(8'b00100110, 3'd7, 1'b1, 8'b01001100, "edge_r7");
        one_word(8'b00100110, 3'd1, 1'b0, 8'b01001100, "edge_l1");

        // Reset with two words in flight.
        arg = 8'hA5; amt = 3'd2; dir = 1'b0; arg_vld = 1'b1; tick();
        arg = 8'h5A; amt = 3'd5; tick();
        arg_vld = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("mid_rst_vld", res_vld, 1'b0);
            chk("mid_rst_res", res, 8'h00);
            tick();
        end
        one_word(8'b10010011, 3'd4, 1'b1, 8'b00111001, "post_rst");

        // Randomized stream with random backpressure.
        accepted = 0;
        cyc = 0;
        while (accepted < 1000 && cyc < 6000) begin
            arg_vld = ($urandom_range(0, 3) != 0);
            arg     = N'($urandom);
            amt     = SW'($urandom);
            dir     = 1'($urandom);
            res_rdy = ($urandom_range(0, 9) < 7);
            #1;
            if (arg_vld && arg_rdy) accepted++;
            tick();
            cyc++;
        end
        chk("rand_accepted", accepted, 1000);
        arg_vld = 1'b0;
        res_rdy = 1'b1;
        repeat (LAT + 3) tick();
        chk("rand_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/circular_shift_pipelined_variable.md
Name: circular_shift_pipelined_variable

Overview:
- Pipelined circular shifter for streamed N-bit words; the rotate amount and direction are chosen at runtime, per word.
- Built as a log2(N)-stage pipeline. Stage k conditionally rotates by 2^k.
- Sits in the arithmetic datapath after fixed-amount rotators and serves their callers when S is not a constant.
- Valid/ready handshake on both sides, with a global-stall backpressure scheme.

Parameters:
- N, 8, data width in bits; must be a power of two and at least 2.
- SW, $clog2(N), width of the rotate-amount field; also the pipeline depth. Derived; do not override.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset.
- arg_vld  input  1  input word valid.
- arg_rdy  output  1  block can accept a word this cycle.
- arg  input  N  input data word.
- amt  input  SW  rotate amount, 0..N-1.
- dir  input  1  rotate direction: 0 = left, 1 = right.
- res_vld  output  1  output word valid.
- res_rdy  input  1  downstream accepts the output word.
- res  output  N  rotated result.

Interface: one clock (clk); reset (rst) is synchronous and active-high.

Behaviour:
- Transfers
  - Input transfer: arg_vld && arg_rdy at a posedge.
  - Output transfer: res_vld && res_rdy at a posedge.
- Stall logic
  - stall = res_vld && !res_rdy.
  - arg_rdy = !stall. This is combinational and depends on res_rdy and the res_vld register.
- Pipeline registers
  - SW stages, each holding vld, data[N], amt[SW] and dir. Stage 0 captures from the input ports.
  - Stage k result = dir ? rotr(prev, 2^k) : rotl(prev, 2^k) when amt bit k is 1; otherwise prev unchanged.
  - Rotation is circular; no bits are lost or zero-filled.
  - Stage k may use either concatenation or shift-OR, but must equal the mathematical rotation exactly.
- Advance and hold
  - When stall = 0, every stage advances by one each cycle.
  - When arg_vld = 0, stage 0 vld loads 0, so the bubble propagates.
  - When stall = 1, every stage holds all its fields, and no input is accepted.
  - Bubbles are not collapsed, so throughput is one word per cycle when not stalled.
- Latency: an accepted word appears on res with res_vld = 1 exactly SW cycles after acceptance, assuming no stall in between. N=8 gives 3 cycles.
- Outputs: res_vld and res come straight from the last stage registers.
  - While res_vld = 1 and res_rdy = 0, res and res_vld must stay stable.
  - When res_vld = 0, res is don't-care but must not be X after reset.
- Reset
  - All vld bits go to 0 and all data/amt/dir registers go to 0.
  - res = 0, res_vld = 0, and arg_rdy = 1 in the first cycle after reset.
- Boundary conditions
  - amt = 0: word passes through unchanged, with full latency.
  - amt = N-1 with dir = 1 gives the same result as amt = 1 with dir = 0.
  - All-zero and all-one words are invariant under any rotation.
  - Simultaneous output transfer and input transfer in the same cycle is legal; neither is lost.
  - Reset asserted mid-operation discards all in-flight words; no stale res_vld afterwards.
  - rst has priority over stall.

Optional Feature:
- Macro: CIRC_SHIFT_OUT_REG_EN.
- Defined: adds one output register stage after stage SW-1.
  - Latency becomes SW+1.
  - The stall rule is unchanged and uses the new last stage's vld.
  - Reset values are the same.
- Undefined: latency is SW, as above. Functional results are identical in both builds.

Test Plan:
- Reset, then send arg=8'b10110101, amt=3, dir=1, res_rdy=1 → res=8'b10110110 with res_vld=1 exactly 3 cycles after acceptance. Same word with dir=0 → 8'b10101101.
- Back-to-back stream of 8 words, 8'b00000001 with amt=0..7 and dir=0, res_rdy=1 → outputs 8'h01, 02, 04, 08, 10, 20, 40, 80 on consecutive cycles; arg_rdy stays 1 throughout.
- Fill the pipe with 3 words, then hold res_rdy=0 for 5 cycles → arg_rdy=0 during the stall; res holds the first result. On release, the 3 results drain in order with no loss or duplication.
- Edge values, N=8, dir=1
  - arg=8'hFF, amt=5 → 8'hFF.
  - arg=8'h00, amt=7 → 8'h00.
  - arg=8'b01100110, amt=3 → 8'b11001100.
  - arg=8'b00100110, amt=7 → 8'b01001100, which also equals left by 1.
- Assert rst for 1 cycle while 2 words are in flight → res_vld=0 for the next 3 cycles and res=0; then a new word is processed correctly.
- Randomised 1000 words with random amt, dir and res_rdy patterns, checked against a reference model → every result matches, in order.
